// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU controller and its
// 1-bit slice. Holds the 3-bit opcode map and the controller state type.
package alu_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOP  = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice.
// Ports:
//   opcode - 3-bit operation select (alu_pkg opcode map)
//   a, b   - operand bits
//   cin    - carry in (used by ADD only)
//   r      - result bit
//   cout   - carry out; full-adder carry for ADD, 0 otherwise
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (opcode)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_NOTA: r = ~a;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_NOP:  r = a;
      OP_ADD: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_XOR:  r = a ^ b;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial WIDTH-bit ALU controller. Latches operands and
// opcode on an accepted start, feeds one bit pair per cycle LSB-first through
// alu_bit_slice, chains the carry for ADD, and publishes the assembled word
// with a one-cycle done pulse.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - request, sampled only while idle
//   opcode     - operation select, latched on accept
//   a, b       - WIDTH-bit operands, latched on accept
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when result/carry_out update
//   result     - last completed result, held until the next completion
//   carry_out  - final carry of the last ADD, 0 for other opcodes
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             slice_r;
  logic             slice_cout;

  alu_bit_slice u_slice (
    .opcode (op_q),
    .a      (sh_a[0]),
    .b      (sh_b[0]),
    .cin    (carry),
    .r      (slice_r),
    .cout   (slice_cout)
  );

  // Shift-right with the new bit entering at the MSB; written this way so
  // WIDTH=1 needs no empty part-select.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = slice_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      acc       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            op_q  <= opcode;
            sh_a  <= a;
            sh_b  <= b;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          acc  <= acc_next;
          cnt  <= cnt + CW'(1);
          if (op_q == OP_ADD) begin
            carry <= slice_cout;
          end
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= acc_next;
            carry_out <= (op_q == OP_ADD) ? slice_cout : 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (WIDTH=8). Expected words come from
// a word-level reference of the opcode map, not from bit-serial modelling.
module tb_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_res  = '0;
  logic         exp_cout = 1'b0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Word-level reference of the opcode map.
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c);
    int unsigned sum;
    c = 1'b0;
    case (op)
      3'd0: r = x | y;
      3'd1: r = x & y;
      3'd2: r = ~x;
      3'd3: r = ~(x | y);
      3'd4: r = ~(x & y);
      3'd5: r = x;
      3'd6: begin
        sum = int'(x) + int'(y);
        r = sum[W-1:0];
        c = sum[W];
      end
      default: r = x ^ y;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from accept to done. glitch >= 0 drives a stray start
  // with different operands after that many processing edges.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int glitch);
    logic [W-1:0] r;
    logic         c;
    ref_op(op, x, y, r, c);
    opcode = op;
    a      = x;
    b      = y;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      if (i == glitch) begin
        start  = 1'b1;
        opcode = op ^ 3'd3;
        a      = W'($urandom);
        b      = W'($urandom);
      end
      step();
      start = 1'b0;
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("result_held", 32'(result), 32'(exp_res));
      chk("carry_held", 32'(carry_out), 32'(exp_cout));
    end
    a = W'($urandom);
    b = W'($urandom);
    step();
    exp_res  = r;
    exp_cout = c;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(exp_res));
    chk("carry_out", 32'(carry_out), 32'(exp_cout));
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_result", 32'(result), 32'(exp_res));
      chk("idle_carry", 32'(carry_out), 32'(exp_cout));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = '0;
    a      = '0;
    b      = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    #10 rst_n = 1'b1;
    idle_check(2);

    // Directed cases.
    run_op(3'd6, 8'hFF, 8'h01, -1);
    run_op(3'd1, 8'hF0, 8'h3C, -1);
    run_op(3'd7, 8'hAA, 8'h0F, -1);   // start driven while done is high
    run_op(3'd2, 8'hA5, 8'h00, -1);
    run_op(3'd5, 8'h3C, 8'hFF, -1);
    run_op(3'd3, 8'h0F, 8'hF0, -1);
    run_op(3'd4, 8'h0F, 8'hF0, -1);
    run_op(3'd0, 8'h81, 8'h18, -1);
    idle_check(1);

    // Start during RUN is ignored.
    run_op(3'd6, 8'h7F, 8'h01, 3);
    idle_check(2);

    // Reset mid-operation.
    opcode = 3'd6;
    a      = 8'hC3;
    b      = 8'h5A;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    exp_res  = '0;
    exp_cout = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    #3 rst_n = 1'b1;
    idle_check(W + 2);

    run_op(3'd6, 8'h10, 8'h20, -1);
    run_op(3'd1, 8'hFF, 8'h0F, -1);   // 0x30 must hold through this RUN

    // Randomized back-to-back operations.
    for (int n = 0; n < 30; n++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle_check(1);
    end
    idle_check(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
